// File: rtl/fsum_sched.sv
// fsum_sched: channel-major sequencer for the full-sum accumulator engine.
// Define FSUM_SCHED_RELU_EN to zero negative final sums on out_data (fp16 ReLU).
module fsum_sched #(
  parameter int unsigned MAX_O_SIDE = 128,
  parameter int unsigned IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      cfg_i_channels,
  input  logic [IDX_W-1:0] cfg_o_bursts,
  input  logic             fifo_empty,
  output logic             eng_start,
  input  logic             eng_ready,
  input  logic [15:0]      eng_result,
  output logic [15:0]      i_channel_count,
  output logic [IDX_W-1:0] fsum_index,
  output logic             wb_en,
  output logic [15:0]      wb_data,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic             protocol_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StIssue,
    StWaitEng,
    StWrite,
    StAdvance,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [15:0]      ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cfg_ch_q, cfg_ch_d;
  logic [IDX_W-1:0] cfg_ob_q, cfg_ob_d;
  logic [15:0]      res_q, res_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             err_q, err_d;
  logic             eng_start_q, eng_start_d;
  logic             wb_en_q, wb_en_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] ob_clamped;
  logic [IDX_W:0]   idx_inc;

  function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef FSUM_SCHED_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  assign ob_clamped = (32'(cfg_o_bursts) > MAX_O_SIDE) ? IDX_W'(MAX_O_SIDE) : cfg_o_bursts;
  assign idx_inc    = {1'b0, idx_q} + (IDX_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    idx_d      = idx_q;
    cfg_ch_d   = cfg_ch_q;
    cfg_ob_d   = cfg_ob_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_ch_d = cfg_i_channels;
          cfg_ob_d = ob_clamped;
          ch_d     = '0;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = (cfg_i_channels == '0 || cfg_o_bursts == '0) ? StDone : StWaitData;
        end
      end
      StWaitData: begin
        if (!fifo_empty) state_d = StIssue;
      end
      StIssue: state_d = StWaitEng;
      StWaitEng: begin
        if (eng_ready) begin
          res_d      = eng_result;
          out_data_d = relu(eng_result);
          state_d    = StWrite;
        end
      end
      StWrite: begin
        // Step the counters on the way into ADVANCE so the new pair is visible there
        // and the completion test below sees the updated channel count.
        state_d = StAdvance;
        if (idx_inc == {1'b0, cfg_ob_q}) begin
          idx_d = '0;
          ch_d  = ch_q + 16'd1;
        end else begin
          idx_d = idx_inc[IDX_W-1:0];
        end
      end
      StAdvance: state_d = (ch_q == cfg_ch_q) ? StDone : StWaitData;
      StDone: begin
        ch_d    = '0;
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (eng_ready && state_q != StWaitEng) err_d = 1'b1;
  end

  // Moore outputs registered from the next state.
  always_comb begin
    eng_start_d = (state_d == StIssue);
    wb_en_d     = (state_d == StWrite);
    out_valid_d = (state_d == StWrite) && (ch_q == cfg_ch_q - 16'd1);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      idx_q       <= '0;
      cfg_ch_q    <= '0;
      cfg_ob_q    <= '0;
      res_q       <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
      wb_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      cfg_ch_q    <= cfg_ch_d;
      cfg_ob_q    <= cfg_ob_d;
      res_q       <= res_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
      wb_en_q     <= wb_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign eng_start       = eng_start_q;
  assign i_channel_count = ch_q;
  assign fsum_index      = idx_q;
  assign wb_en           = wb_en_q;
  assign wb_data         = res_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign protocol_err    = err_q;

endmodule

// File: tb/tb_fsum_sched.sv
// Self-checking bench for fsum_sched: table-driven layers, hand-written corner sequences
// and randomized layers, all checked against a nested-loop reference of the pair walk.
module tb_fsum_sched;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned MAX_O_SIDE = 128;

`ifdef FSUM_SCHED_RELU_EN
  localparam logic [15:0] ExpNeg     = 16'h0000;
  localparam logic [15:0] ExpNegZero = 16'h0000;
`else
  localparam logic [15:0] ExpNeg     = 16'hC200;
  localparam logic [15:0] ExpNegZero = 16'h8000;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      cfg_i_channels;
  logic [IDX_W-1:0] cfg_o_bursts;
  logic             fifo_empty;
  logic             eng_start;
  logic             eng_ready;
  logic [15:0]      eng_result;
  logic [15:0]      i_channel_count;
  logic [IDX_W-1:0] fsum_index;
  logic             wb_en;
  logic [15:0]      wb_data;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             busy;
  logic             done;
  logic             protocol_err;

  logic        resp_rdy, stray_rdy;
  logic [15:0] resp_data, stray_data;
  logic        eng_auto, fix_en;
  logic [15:0] fix_val;
  int          eng_delay;

  assign eng_ready  = resp_rdy | stray_rdy;
  assign eng_result = resp_rdy ? resp_data : stray_data;

  fsum_sched #(.MAX_O_SIDE(MAX_O_SIDE), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_i_channels(cfg_i_channels),
    .cfg_o_bursts(cfg_o_bursts), .fifo_empty(fifo_empty), .eng_start(eng_start),
    .eng_ready(eng_ready), .eng_result(eng_result), .i_channel_count(i_channel_count),
    .fsum_index(fsum_index), .wb_en(wb_en), .wb_data(wb_data), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .done(done), .protocol_err(protocol_err)
  );

  logic [61:0] outs_all;
  assign outs_all = {eng_start, i_channel_count, fsum_index, wb_en, wb_data, out_valid,
                     out_data, busy, done, protocol_err};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] relu_ref(input logic [15:0] x);
`ifdef FSUM_SCHED_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  // Observation logs, written only by the monitor and responder.
  int          es_cyc[$];
  logic [47:0] wb_log[$];
  logic [31:0] out_log[$];
  logic [15:0] sent[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_busy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (eng_start) es_cyc.push_back(cyc);
      if (wb_en) wb_log.push_back({i_channel_count, 8'h00, fsum_index, wb_data});
      if (out_valid) out_log.push_back({8'h00, fsum_index, out_data});
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
    end
  end

  // Engine model: answers each eng_start after eng_delay cycles with a single-cycle eng_ready.
  initial begin
    int d;
    resp_rdy  = 1'b0;
    resp_data = '0;
    forever begin
      @(negedge clk);
      if (eng_start && eng_auto) begin
        d = eng_delay;
        repeat (d) @(posedge clk);
        #1;
        if (eng_auto) begin
          resp_data = fix_en ? fix_val : 16'($urandom);
          resp_rdy  = 1'b1;
          sent.push_back(resp_data);
          @(posedge clk);
          #1;
          resp_rdy = 1'b0;
        end
      end
    end
  end

  task automatic run_layer(input int ch, input int bu, input int fifo_rand, input int dly,
                           input int hold, input int exp_jobs, input int exp_outs);
    int es_base, wb_base, out_base, s_base, d_base, start_cyc, first_low, budget;
    int b_eff, k, o, lat;
    logic [47:0] e_wb;
    logic [31:0] e_out;
    es_base  = es_cyc.size();
    wb_base  = wb_log.size();
    out_base = out_log.size();
    s_base   = sent.size();
    d_base   = done_cnt;
    eng_delay = dly;
    eng_auto  = 1'b1;
    cfg_i_channels = 16'(ch);
    cfg_o_bursts   = 8'(bu);
    fifo_empty     = 1'b1;
    start          = 1'b1;
    start_cyc      = cyc;
    tick();
    start          = 1'b0;
    cfg_i_channels = 16'($urandom);
    cfg_o_bursts   = 8'($urandom);
    first_low = -1;
    budget    = 60 + exp_jobs * (dly + 6) * 6;
    for (int c = 0; c < budget && done_cnt == d_base; c++) begin
      if (c < hold) fifo_empty = 1'b1;
      else if (fifo_rand != 0) fifo_empty = ($urandom_range(2) == 0);
      else fifo_empty = 1'b0;
      if (!fifo_empty && first_low < 0) first_low = cyc;
      tick();
    end
    fifo_empty = 1'b0;
    chk("done_pulse_count", 64'(done_cnt - d_base), 64'(1));
    chk("busy_during_done", 64'(done_busy), 64'(1));
    chk("busy_done_low_after", {62'd0, busy, done}, 64'd0);
    chk("no_protocol_err", 64'(protocol_err), 64'(0));
    chk("eng_start_count", 64'(es_cyc.size() - es_base), 64'(exp_jobs));
    chk("wb_en_count", 64'(wb_log.size() - wb_base), 64'(exp_jobs));
    chk("out_valid_count", 64'(out_log.size() - out_base), 64'(exp_outs));

    // Reference walk: channel-major over (channel, burst) pairs, bursts clamped.
    b_eff = (bu > int'(MAX_O_SIDE)) ? int'(MAX_O_SIDE) : bu;
    k = 0;
    o = 0;
    for (int c = 0; c < ch; c++) begin
      for (int b = 0; b < b_eff; b++) begin
        if (wb_base + k < wb_log.size() && s_base + k < sent.size()) begin
          e_wb = {16'(c), 16'(b), sent[s_base + k]};
          chk("wb_pair_data", 64'(wb_log[wb_base + k]), 64'(e_wb));
        end
        if (c == ch - 1 && out_base + o < out_log.size() && s_base + k < sent.size()) begin
          e_out = {16'(b), relu_ref(sent[s_base + k])};
          chk("out_idx_data", 64'(out_log[out_base + o]), 64'(e_out));
          o++;
        end
        k++;
      end
    end

    if (exp_jobs > 0 && es_cyc.size() - es_base == exp_jobs) begin
      chk("issue_after_fifo", 64'(es_cyc[es_base] - first_low), 64'(1));
      if (fifo_rand == 0 && hold == 0) begin
        chk("first_issue_lat", 64'(es_cyc[es_base] - start_cyc), 64'(2));
        for (int j = 1; j < exp_jobs; j++)
          chk("issue_spacing", 64'(es_cyc[es_base + j] - es_cyc[es_base + j - 1]),
              64'(dly + 4));
        chk("done_lat", 64'(done_cyc - es_cyc[es_base + exp_jobs - 1]), 64'(dly + 3));
      end
    end
    if (exp_jobs == 0) begin
      lat = done_cyc - start_cyc;
      chk("zero_cfg_done_lat", 64'(lat >= 1 && lat <= 2), 64'(1));
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int c = 0; c < budget && done_cnt == d0; c++) tick();
    chk(name, 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic relu_case(input logic [15:0] val, input logic [15:0] exp_out);
    logic [47:0] w;
    logic [31:0] r;
    fix_en  = 1'b1;
    fix_val = val;
    run_layer(1, 1, 0, 2, 0, 1, 1);
    fix_en = 1'b0;
    if (wb_log.size() > 0 && out_log.size() > 0) begin
      w = wb_log[wb_log.size() - 1];
      r = out_log[out_log.size() - 1];
      chk("relu_wb_data", 64'(w[15:0]), 64'(val));
      chk("relu_out_data", 64'(r[15:0]), 64'(exp_out));
    end
  endtask

  typedef struct {
    int ch;
    int bu;
    int fifo_rand;
    int dly;
    int exp_jobs;
    int exp_outs;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int es0, rc, rb, rd;
    tbl[0] = '{2, 3, 0, 5, 6, 3};
    tbl[1] = '{1, 1, 0, 1, 1, 1};
    tbl[2] = '{3, 2, 1, 3, 6, 2};
    tbl[3] = '{1, 4, 0, 2, 4, 4};
    tbl[4] = '{2, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 3, 0, 1, 0, 0};
    tbl[6] = '{1, 130, 0, 1, 128, 128};

    rst = 1'b1; start = 1'b0; cfg_i_channels = '0; cfg_o_bursts = '0; fifo_empty = 1'b1;
    stray_rdy = 1'b0; stray_data = '0; eng_auto = 1'b0; fix_en = 1'b0; fix_val = '0;
    eng_delay = 1;
    repeat (3) tick();
    chk("reset_outputs_in_rst", 64'(outs_all), 64'd0);
    rst = 1'b0;
    tick();
    chk("reset_outputs_after", 64'(outs_all), 64'd0);

    foreach (tbl[i])
      run_layer(tbl[i].ch, tbl[i].bu, tbl[i].fifo_rand, tbl[i].dly, 0,
                tbl[i].exp_jobs, tbl[i].exp_outs);

    // FIFO empty for 10 cycles in WAIT_DATA holds off the first job.
    run_layer(1, 2, 0, 2, 10, 2, 2);

    // Stray eng_ready while waiting for data.
    eng_auto = 1'b1; eng_delay = 2; fifo_empty = 1'b1;
    cfg_i_channels = 16'd1; cfg_o_bursts = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stray_data = 16'h1234; stray_rdy = 1'b1;
    tick();
    stray_rdy = 1'b0;
    chk("stray_sets_err", 64'(protocol_err), 64'(1));
    chk("stray_state_kept", {38'd0, i_channel_count, fsum_index, wb_en, busy},
        {38'd0, 16'd0, 8'd0, 1'b0, 1'b1});
    fifo_empty = 1'b0;
    wait_done("stray_layer_done", 200);
    chk("err_sticky", 64'(protocol_err), 64'(1));
    cfg_i_channels = 16'd1; cfg_o_bursts = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_err", 64'(protocol_err), 64'(0));
    wait_done("clear_layer_done", 200);
    tick();

    // Reset while waiting on the engine.
    eng_auto = 1'b1; eng_delay = 6; fifo_empty = 1'b0;
    cfg_i_channels = 16'd2; cfg_o_bursts = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    es0 = es_cyc.size();
    for (int c = 0; c < 20 && es_cyc.size() == es0; c++) tick();
    chk("rst_seq_issue_seen", 64'(es_cyc.size() - es0), 64'(1));
    tick();
    tick();
    chk("rst_seq_busy_before", 64'(busy), 64'(1));
    eng_auto = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 64'(outs_all), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    es0 = es_cyc.size();
    repeat (10) tick();
    chk("no_issue_after_rst", 64'(es_cyc.size() - es0), 64'(0));
    chk("idle_outputs_after_rst", 64'(outs_all), 64'd0);
    run_layer(2, 2, 0, 3, 0, 4, 2);

    relu_case(16'hC200, ExpNeg);
    relu_case(16'h4200, 16'h4200);
    relu_case(16'h8000, ExpNegZero);

    for (int n = 0; n < 6; n++) begin
      rc = $urandom_range(3, 1);
      rb = $urandom_range(5, 1);
      rd = $urandom_range(4, 1);
      run_layer(rc, rb, 1, rd, 0, rc * rb, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
